// File: rtl/mbc1_mapper.sv
`default_nettype none
// ============================================================================
// mbc1_mapper -- MBC1 bank controller: bank/control latches, ROM/cart-RAM
// address translation and a 2-clk registered read return path.
// Revision: 1.0
// ============================================================================
module mbc1_mapper #(
  parameter int ROM_AW = 19,
  parameter int RAM_AW = 13
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       cart_a,
  input  logic [7:0]        cart_wdata,
  output logic [7:0]        cart_rdata,
  input  logic              cart_wr,
  input  logic              cart_rd,
  input  logic              cart_cs,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [7:0]        rom_q,
  output logic [RAM_AW-1:0] ram_a,
  output logic [7:0]        ram_d,
  output logic              ram_we,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ROM  = 2'd1,
    SEL_RAM  = 2'd2
  } sel_e;

  logic              wr_q;
  logic              ram_en_q, ram_en_d;
  logic [4:0]        bank1_q, bank1_d;
  logic [1:0]        bank2_q, bank2_d;
  logic              mode_q, mode_d;
  logic [ROM_AW-1:0] rom_a_q, rom_a_d;
  logic [RAM_AW-1:0] ram_a_q, ram_a_d;
  logic [7:0]        ram_d_q, ram_d_d;
  logic              ram_we_q, ram_we_d;
  sel_e              sel1_q, sel1_d, sel2_q;
  logic [7:0]        rdata_q, rdata_d;

  logic              w_commit;
  logic              w_in_rom;
  logic              w_in_ram;
  logic [1:0]        w_hi_bank;

  assign w_commit  = cart_wr & cart_cs & ~wr_q;
  assign w_in_rom  = ~cart_a[15];
  assign w_in_ram  = (cart_a[15:13] == 3'b101);
  assign w_hi_bank = mode_q ? bank2_q : 2'b00;

  always_comb begin
    ram_en_d = ram_en_q;
    bank1_d  = bank1_q;
    bank2_d  = bank2_q;
    mode_d   = mode_q;
    ram_d_d  = ram_d_q;
    ram_we_d = 1'b0;
    sel1_d   = SEL_NONE;
    rdata_d  = 8'hFF;

    if (w_commit) begin
      case (cart_a[15:13])
        3'b000: ram_en_d = (cart_wdata[3:0] == 4'hA);
        3'b001: bank1_d  = (cart_wdata[4:0] == 5'd0) ? 5'd1 : cart_wdata[4:0];
        3'b010: bank2_d  = cart_wdata[1:0];
        3'b011: mode_d   = cart_wdata[0];
        3'b101: begin
          if (ram_en_q) begin
            ram_we_d = 1'b1;
            ram_d_d  = cart_wdata;
          end
        end
        default: ;
      endcase
    end

    // Upper bits beyond the configured width fall off, wrapping banks modulo size.
    if (cart_a[14]) rom_a_d = ROM_AW'({bank2_q, bank1_q, cart_a[13:0]});
    else            rom_a_d = ROM_AW'({w_hi_bank, 5'd0, cart_a[13:0]});
    ram_a_d = RAM_AW'({w_hi_bank, cart_a[12:0]});

    if (cart_rd & cart_cs) begin
      if (w_in_rom)                  sel1_d = SEL_ROM;
      else if (w_in_ram && ram_en_q) sel1_d = SEL_RAM;
    end

    case (sel2_q)
      SEL_ROM: rdata_d = rom_q;
      SEL_RAM: rdata_d = ram_q;
      default: rdata_d = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q     <= 1'b0;
      ram_en_q <= 1'b0;
      bank1_q  <= 5'd1;
      bank2_q  <= 2'd0;
      mode_q   <= 1'b0;
      rom_a_q  <= '0;
      ram_a_q  <= '0;
      ram_d_q  <= 8'h00;
      ram_we_q <= 1'b0;
      sel1_q   <= SEL_NONE;
      sel2_q   <= SEL_NONE;
      rdata_q  <= 8'hFF;
    end else begin
      wr_q     <= cart_wr & cart_cs;
      ram_en_q <= ram_en_d;
      bank1_q  <= bank1_d;
      bank2_q  <= bank2_d;
      mode_q   <= mode_d;
      rom_a_q  <= rom_a_d;
      ram_a_q  <= ram_a_d;
      ram_d_q  <= ram_d_d;
      ram_we_q <= ram_we_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel1_q;
      rdata_q  <= rdata_d;
    end
  end

  assign cart_rdata = rdata_q;
  assign rom_a      = rom_a_q;
  assign ram_a      = ram_a_q;
  assign ram_d      = ram_d_q;
  assign ram_we     = ram_we_q;

endmodule
`default_nettype wire

// File: tb/tb_mbc1_mapper.sv
`default_nettype none
// ============================================================================
// tb_mbc1_mapper -- directed stimulus with a queued scoreboard for mbc1_mapper.
// Revision: 1.0
// ============================================================================
module tb_mbc1_mapper;

  localparam int ROM_AW = 21;
  localparam int RAM_AW = 13;

  localparam int K_RDATA = 0;
  localparam int K_ROMA  = 1;
  localparam int K_RAMA  = 2;
  localparam int K_WE    = 3;
  localparam int K_RAMD  = 4;

  typedef struct {
    int          due;
    int          kind;
    logic [31:0] exp;
    string       nm;
  } chk_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [15:0]       cart_a = 16'h0000;
  logic [7:0]        cart_wdata = 8'h00;
  logic [7:0]        cart_rdata;
  logic              cart_wr = 1'b0;
  logic              cart_rd = 1'b0;
  logic              cart_cs = 1'b0;
  logic [ROM_AW-1:0] rom_a;
  logic [7:0]        rom_q = 8'h00;
  logic [RAM_AW-1:0] ram_a;
  logic [7:0]        ram_d;
  logic              ram_we;
  logic [7:0]        ram_q = 8'h00;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  chk_t sb[$];
  logic [7:0] exp_ramd = 8'h00;

  mbc1_mapper #(.ROM_AW(ROM_AW), .RAM_AW(RAM_AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .cart_a     (cart_a),
    .cart_wdata (cart_wdata),
    .cart_rdata (cart_rdata),
    .cart_wr    (cart_wr),
    .cart_rd    (cart_rd),
    .cart_cs    (cart_cs),
    .rom_a      (rom_a),
    .rom_q      (rom_q),
    .ram_a      (ram_a),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .ram_q      (ram_q)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_fn(input logic [20:0] a);
    return a[7:0] ^ a[15:8] ^ {3'b000, a[20:16]} ^ 8'h3C;
  endfunction

  function automatic logic [7:0] ram_fn(input logic [12:0] a);
    return a[7:0] ^ {3'b000, a[12:8]} ^ 8'hC5;
  endfunction

  // Synchronous memories: data follows the address by one clock.
  always @(posedge clk) begin
    rom_q <= rom_fn(rom_a);
    ram_q <= ram_fn(ram_a);
  end

  task automatic push(input int due, input int kind, input logic [31:0] exp, input string nm);
    sb.push_back('{due, kind, exp, nm});
  endtask

  // Monitor: pops every expectation that has come due and compares it.
  initial begin : monitor
    chk_t        c;
    logic [31:0] act;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        c = sb.pop_front();
        case (c.kind)
          K_RDATA: act = {24'd0, cart_rdata};
          K_ROMA:  act = {11'd0, rom_a};
          K_RAMA:  act = {19'd0, ram_a};
          K_WE:    act = {31'd0, ram_we};
          default: act = {24'd0, ram_d};
        endcase
        checks++;
        if (c.due != cyc || act !== c.exp) begin
          errors++;
          $display("FAIL %s cyc=%0d due=%0d actual=0x%0h required=0x%0h",
                   c.nm, cyc, c.due, act, c.exp);
        end
      end
    end
  end

  // region: 0 = unmapped, 1 = ROM, 2 = cart RAM
  task automatic do_read(input logic [15:0] addr, input logic [31:0] exp_a,
                         input int region, input bit ram_on, input string nm);
    int t;
    @(negedge clk);
    t = cyc;
    cart_a = addr; cart_rd = 1'b1; cart_cs = 1'b1;
    if (region == 1) begin
      push(t + 1, K_ROMA, exp_a, {nm, ".rom_a"});
      push(t + 3, K_RDATA, {24'd0, rom_fn(exp_a[20:0])}, {nm, ".rdata"});
    end else if (region == 2) begin
      push(t + 1, K_RAMA, exp_a, {nm, ".ram_a"});
      push(t + 3, K_RDATA, ram_on ? {24'd0, ram_fn(exp_a[12:0])} : 32'hFF, {nm, ".rdata"});
    end else begin
      push(t + 3, K_RDATA, 32'hFF, {nm, ".rdata"});
    end
    push(t + 4, K_RDATA, 32'hFF, {nm, ".idle_rdata"});
    @(negedge clk);
    cart_rd = 1'b0; cart_cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] data, input int hold,
                          input bit we_exp, input logic [31:0] exp_ram_a, input string nm);
    int t;
    @(negedge clk);
    t = cyc;
    cart_a = addr; cart_wdata = data; cart_wr = 1'b1; cart_cs = 1'b1;
    if (we_exp) exp_ramd = data;
    push(t + 1, K_WE, {31'd0, we_exp}, {nm, ".ram_we"});
    push(t + 1, K_RAMD, {24'd0, exp_ramd}, {nm, ".ram_d"});
    if (we_exp) push(t + 1, K_RAMA, exp_ram_a, {nm, ".ram_a"});
    for (int i = 2; i <= hold + 1; i++) push(t + i, K_WE, 32'd0, {nm, ".ram_we_hold"});
    repeat (hold) @(negedge clk);
    cart_wr = 1'b0; cart_cs = 1'b0;
  endtask

  initial begin : stim
    int t;
    for (int d = 1; d <= 2; d++) begin
      push(d, K_RDATA, 32'hFF, "reset.rdata");
      push(d, K_ROMA,  32'd0,  "reset.rom_a");
      push(d, K_RAMA,  32'd0,  "reset.ram_a");
      push(d, K_WE,    32'd0,  "reset.ram_we");
      push(d, K_RAMD,  32'd0,  "reset.ram_d");
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cart_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL hold_rst.rdata actual=0x%0h required=0xff", cart_rdata);
    end
    checks++;
    if (rom_a !== '0) begin
      errors++;
      $display("FAIL hold_rst.rom_a actual=0x%0h required=0x0", rom_a);
    end
    checks++;
    if (ram_a !== '0) begin
      errors++;
      $display("FAIL hold_rst.ram_a actual=0x%0h required=0x0", ram_a);
    end
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL hold_rst.ram_we actual=%b required=0", ram_we);
    end
    checks++;
    if (ram_d !== 8'h00) begin
      errors++;
      $display("FAIL hold_rst.ram_d actual=0x%0h required=0x0", ram_d);
    end
    rst = 1'b0;

    // Bank 1 default, zero and 5-bit bank selects
    do_read(16'h4000, 32'h04000, 1, 0, "bank1_default");
    do_write(16'h2000, 8'h00, 1, 0, 0, "wr_bank1_00");
    do_read(16'h4123, 32'h04123, 1, 0, "bank1_zero_is_1");
    do_write(16'h2000, 8'h13, 1, 0, 0, "wr_bank1_13");
    do_read(16'h4123, 32'h4C123, 1, 0, "bank1_13");
    do_write(16'h2000, 8'h10, 1, 0, 0, "wr_bank1_10");
    do_read(16'h4000, 32'h40000, 1, 0, "bank1_10");
    do_write(16'h2000, 8'h20, 1, 0, 0, "wr_bank1_20");
    do_read(16'h4000, 32'h04000, 1, 0, "bank1_20_is_1");

    // Cart RAM enable gating and unmapped region
    do_read(16'hA000, 32'h0000, 2, 0, "ram_rd_disabled");
    do_write(16'hA005, 8'h11, 1, 0, 0, "ram_wr_disabled");
    do_read(16'hC000, 32'h0, 0, 0, "unmapped_rd");
    do_write(16'h0000, 8'h0A, 1, 0, 0, "ram_enable");
    do_write(16'hA005, 8'h5A, 1, 1, 32'h0005, "ram_wr_5A");
    do_read(16'hA005, 32'h0005, 2, 1, "ram_rd_enabled");

    // Upper bank bits and banking mode
    do_write(16'h4000, 8'h02, 1, 0, 0, "wr_bank2_2");
    do_read(16'h0010, 32'h000010, 1, 0, "mode0_low_rom");
    do_write(16'h6000, 8'h01, 1, 0, 0, "wr_mode_1");
    do_read(16'h0010, 32'h100010, 1, 0, "mode1_low_rom");
    do_read(16'h4000, 32'h104000, 1, 0, "mode1_high_rom");

    // Long-held writes commit once
    do_write(16'hA000, 8'h77, 4, 1, 32'h0000, "ram_wr_held");
    do_write(16'h2000, 8'h05, 4, 0, 0, "bank1_wr_held");
    do_read(16'h4000, 32'h114000, 1, 0, "bank1_05");

    // Reset during a bank write
    @(negedge clk);
    t = cyc;
    cart_a = 16'h2000; cart_wdata = 8'h07; cart_wr = 1'b1; cart_cs = 1'b1;
    #2 rst = 1'b1;
    push(t + 1, K_RDATA, 32'hFF, "rst_mid.rdata");
    push(t + 1, K_WE,    32'd0,  "rst_mid.ram_we");
    push(t + 1, K_ROMA,  32'd0,  "rst_mid.rom_a");
    push(t + 1, K_RAMD,  32'd0,  "rst_mid.ram_d");
    exp_ramd = 8'h00;
    @(negedge clk);
    checks++;
    if (cart_rdata !== 8'hFF) begin
      errors++;
      $display("FAIL rst_mid_direct.rdata actual=0x%0h required=0xff", cart_rdata);
    end
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_direct.ram_we actual=%b required=0", ram_we);
    end
    checks++;
    if (rom_a !== '0) begin
      errors++;
      $display("FAIL rst_mid_direct.rom_a actual=0x%0h required=0x0", rom_a);
    end
    cart_wr = 1'b0; cart_cs = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_read(16'h4000, 32'h04000, 1, 0, "after_rst_bank");
    do_read(16'hA000, 32'h0000, 2, 0, "after_rst_ram_off");

    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
